// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

    localparam int FQ_DEPTH     = 16;
    localparam int FQ_PTR_WIDTH = $clog2(FQ_DEPTH);
    localparam int FQ_VALEN     = 32;
    localparam int EXCP_CODE_W  = 6;

    // Address error on fetch.
    localparam logic [EXCP_CODE_W-1:0] ECODE_ADE = 6'h08;

    // Fetch exception carried alongside a response.
    typedef struct packed {
        logic                   valid;
        logic [EXCP_CODE_W-1:0] ecode;
    } ExcpSt;

    // One queued instruction.
    typedef struct packed {
        logic [31:0]         instr;
        logic [FQ_VALEN-1:0] vaddr;
        logic [FQ_VALEN-1:0] npc;
        ExcpSt               excp;
    } FqEntrySt;

endpackage

// File: rtl/fetch_queue_lane_compact.sv
// Combinational lane compaction: each valid lane gets the write offset equal
// to the number of valid lanes below it, so valid lanes pack in lane order.
module fetch_lane_compact #(
    parameter int FETCH_WIDTH = 2,
    localparam int CNT_W      = $clog2(FETCH_WIDTH + 1)
) (
    input  logic [FETCH_WIDTH-1:0]            i_valid,
    output logic [FETCH_WIDTH-1:0][CNT_W-1:0] o_offset,
    output logic [CNT_W-1:0]                  o_n_enq
);

    logic [CNT_W-1:0] w_run;

    // Running prefix count of valid lanes gives each lane its slot.
    always_comb begin
        w_run    = '0;
        o_offset = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            o_offset[i] = w_run;
            if (i_valid[i]) begin
                w_run = w_run + CNT_W'(1);
            end
        end
        o_n_enq = w_run;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: compacts ICache response lanes into a circular
// buffer and presents the oldest entries to decode in program order.
//
// Handshake: enqueue happens when any in_valid lane is set while in_ready is
// high and no flush is active; in_ready depends only on registered state.
// Decode consumes every asserted out_valid lane in a cycle where dec_ready=1.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int FETCH_WIDTH  = 2,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = FQ_DEPTH,
    parameter int VALEN        = FQ_VALEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [FETCH_WIDTH-1:0]       in_valid,
    input  logic [FETCH_WIDTH*32-1:0]    in_instr,
    input  logic [FETCH_WIDTH*VALEN-1:0] in_vaddr,
    input  logic [FETCH_WIDTH*VALEN-1:0] in_npc,
    input  ExcpSt                        in_excp,
    output logic                         in_ready,
    output logic [DECODE_WIDTH-1:0]      out_valid,
    output FqEntrySt [DECODE_WIDTH-1:0]  out_entry,
    input  logic                         dec_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(FETCH_WIDTH + 1);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_excp_hold;
    FqEntrySt      r_mem [DEPTH];

    logic                          w_enq_fire;
    logic [FETCH_WIDTH-1:0]        w_lane_valid;
    logic [FETCH_WIDTH-1:0][OW-1:0] w_offset;
    logic [OW-1:0]                 w_n_enq;
    logic [CW-1:0]                 w_n_deq;
    FqEntrySt [FETCH_WIDTH-1:0]    w_wr_entry;

    // Full-response space check; no bypass from a same-cycle dequeue.
    assign in_ready     = (r_count <= CW'(DEPTH - FETCH_WIDTH)) & ~r_excp_hold;
    assign w_enq_fire   = (|in_valid) & in_ready & ~flush_i & ~rst;
    assign w_lane_valid = in_valid & {FETCH_WIDTH{w_enq_fire}};

    fetch_lane_compact #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_compact (
        .i_valid  (w_lane_valid),
        .o_offset (w_offset),
        .o_n_enq  (w_n_enq)
    );

    // Assemble per-lane entries; the response exception tags every lane.
    always_comb begin
        w_wr_entry = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_wr_entry[i].instr = in_instr[i*32 +: 32];
            w_wr_entry[i].vaddr = in_vaddr[i*VALEN +: VALEN];
            w_wr_entry[i].npc   = in_npc[i*VALEN +: VALEN];
            w_wr_entry[i].excp  = in_excp;
        end
    end

    // Decode takes as many entries as are shown, capped at its width.
    always_comb begin
        w_n_deq = '0;
        if (dec_ready) begin
            if (r_count >= CW'(DECODE_WIDTH)) begin
                w_n_deq = CW'(DECODE_WIDTH);
            end else begin
                w_n_deq = r_count;
            end
        end
    end

    // Pointer, occupancy and exception-hold state; flush behaves like reset.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_excp_hold <= 1'b0;
        end else begin
            r_head  <= r_head + w_n_deq[PW-1:0];
            r_tail  <= r_tail + PW'(w_n_enq);
            r_count <= r_count + CW'(w_n_enq) - w_n_deq;
            if (w_enq_fire && in_excp.valid) begin
                r_excp_hold <= 1'b1;
            end
        end
    end

    // Storage writes: packed lanes land at consecutive slots from tail.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (w_lane_valid[i]) begin
                r_mem[r_tail + PW'(w_offset[i])] <= w_wr_entry[i];
            end
        end
    end

    // Oldest entries read straight out of the array starting at head.
    always_comb begin
        out_valid = '0;
        out_entry = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            out_valid[i] = (r_count > CW'(i));
            out_entry[i] = r_mem[r_head + PW'(i)];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/back-pressure, compaction, steady-state
// streaming with wrap, exception hold, and flush/reset mid-operation.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int FW = 2;
  localparam int DW = 2;
  localparam int VA = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush_i = 1'b0;
  logic [FW-1:0]     in_valid = '0;
  logic [FW*32-1:0]  in_instr = '0;
  logic [FW*VA-1:0]  in_vaddr = '0;
  logic [FW*VA-1:0]  in_npc = '0;
  ExcpSt             in_excp = '0;
  logic              in_ready;
  logic [DW-1:0]     out_valid;
  FqEntrySt [DW-1:0] out_entry;
  logic              dec_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  fetch_queue #(
    .FETCH_WIDTH  (FW),
    .DECODE_WIDTH (DW),
    .DEPTH        (16),
    .VALEN        (VA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_vaddr  (in_vaddr),
    .in_npc    (in_npc),
    .in_excp   (in_excp),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_entry (out_entry),
    .dec_ready (dec_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  // advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver: instr word and npc are derived from the PC so they can be checked too
  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    in_valid = v;
    in_vaddr = {pc1, pc0};
    in_npc   = {pc1 + 32'd4, pc0 + 32'd4};
    in_instr = {pc1 ^ 32'hA5A5_0000, pc0 ^ 32'hA5A5_0000};
  endtask

  task automatic idle();
    in_valid = '0;
    in_excp  = '0;
  endtask

  // pop two expected PCs and compare against both output lanes
  task automatic check_pair(input string tag);
    logic [31:0] e0;
    logic [31:0] e1;
    e0 = exp_q.pop_front();
    e1 = exp_q.pop_front();
    check({tag, "_valid"}, out_valid, 2'b11);
    check({tag, "_pc0"}, out_entry[0].vaddr, e0);
    check({tag, "_pc1"}, out_entry[1].vaddr, e1);
  endtask

  // flush or reset with count=10 while new input and dec_ready are present
  task automatic midop(input bit use_rst, input logic [31:0] base);
    dec_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(2'b11, base + 32'(8 * k), base + 32'(8 * k + 4));
      step();
    end
    idle();
    check("midop_full10_valid", out_valid, 2'b11);
    check("midop_full10_ready", in_ready, 1'b1);
    if (use_rst) rst = 1'b1; else flush_i = 1'b1;
    drive(2'b11, 32'h1c00_ee00, 32'h1c00_ee04);
    dec_ready = 1'b1;
    step();
    rst = 1'b0;
    flush_i = 1'b0;
    idle();
    check("midop_after_valid", out_valid, 2'b00);
    check("midop_after_ready", in_ready, 1'b1);
    step();
    step();
    check("midop_later_valid", out_valid, 2'b00);
    dec_ready = 1'b0;
    drive(2'b11, 32'h1c00_f000, 32'h1c00_f004);
    step();
    idle();
    check("midop_new_valid", out_valid, 2'b11);
    check("midop_new_pc0", out_entry[0].vaddr, 32'h1c00_f000);
    check("midop_new_pc1", out_entry[1].vaddr, 32'h1c00_f004);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check("midop_drained", out_valid, 2'b00);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_valid", out_valid, 2'b00);
    check("reset_ready", in_ready, 1'b1);

    // empty queue ignores dec_ready
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check("empty_deq_valid", out_valid, 2'b00);
    check("empty_deq_ready", in_ready, 1'b1);

    // fill: eight full responses, then back-pressure
    for (int k = 0; k < 8; k++) begin
      check("fill_ready", in_ready, 1'b1);
      drive(2'b11, 32'h1c00_0000 + 32'(8 * k), 32'h1c00_0004 + 32'(8 * k));
      step();
    end
    idle();
    check("fill_full_ready", in_ready, 1'b0);
    check("fill_valid", out_valid, 2'b11);
    check("fill_pc0", out_entry[0].vaddr, 32'h1c00_0000);
    check("fill_pc1", out_entry[1].vaddr, 32'h1c00_0004);
    check("fill_npc0", out_entry[0].npc, 32'h1c00_0004);
    check("fill_instr1", out_entry[1].instr, 32'hB9A5_0004);
    // offered while full: must be dropped
    drive(2'b11, 32'h1c00_0f00, 32'h1c00_0f04);
    step();
    idle();
    dec_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", out_valid, 2'b11);
      check("drain_pc0", out_entry[0].vaddr, 32'h1c00_0000 + 32'(8 * k));
      check("drain_pc1", out_entry[1].vaddr, 32'h1c00_0004 + 32'(8 * k));
      step();
    end
    dec_ready = 1'b0;
    check("drain_empty", out_valid, 2'b00);
    check("drain_ready", in_ready, 1'b1);

    // compaction
    drive(2'b10, 32'hdead_0000, 32'h1c00_0014);
    step();
    drive(2'b11, 32'h1c00_0018, 32'h1c00_001c);
    step();
    idle();
    check("cmp_valid", out_valid, 2'b11);
    check("cmp_pc0", out_entry[0].vaddr, 32'h1c00_0014);
    check("cmp_pc1", out_entry[1].vaddr, 32'h1c00_0018);
    dec_ready = 1'b1;
    step();
    check("cmp_count1_valid", out_valid, 2'b01);
    check("cmp_pc2", out_entry[0].vaddr, 32'h1c00_001c);
    step();
    dec_ready = 1'b0;
    check("cmp_empty", out_valid, 2'b00);

    // concurrent steady state: count held at 4 over 40 cycles
    for (int k = 0; k < 2; k++) begin
      drive(2'b11, 32'h1c00_1000 + 32'(8 * k), 32'h1c00_1004 + 32'(8 * k));
      exp_q.push_back(32'h1c00_1000 + 32'(8 * k));
      exp_q.push_back(32'h1c00_1004 + 32'(8 * k));
      step();
    end
    dec_ready = 1'b1;
    for (int k = 2; k < 42; k++) begin
      drive(2'b11, 32'h1c00_1000 + 32'(8 * k), 32'h1c00_1004 + 32'(8 * k));
      exp_q.push_back(32'h1c00_1000 + 32'(8 * k));
      exp_q.push_back(32'h1c00_1004 + 32'(8 * k));
      check("ss_ready", in_ready, 1'b1);
      check_pair("ss");
      step();
    end
    idle();
    check_pair("ss_tail_a");
    step();
    check_pair("ss_tail_b");
    step();
    dec_ready = 1'b0;
    check("ss_empty", out_valid, 2'b00);
    check("ss_queue_left", 64'(exp_q.size()), 64'd0);

    // exception hold
    drive(2'b11, 32'h1c00_2000, 32'h1c00_2004);
    in_excp.valid = 1'b1;
    in_excp.ecode = ECODE_ADE;
    step();
    idle();
    check("excp_ready", in_ready, 1'b0);
    check("excp_valid", out_valid, 2'b11);
    check("excp_l0_valid", out_entry[0].excp.valid, 1'b1);
    check("excp_l0_ecode", out_entry[0].excp.ecode, ECODE_ADE);
    check("excp_l1_ecode", out_entry[1].excp.ecode, ECODE_ADE);
    drive(2'b11, 32'h1c00_2100, 32'h1c00_2104);
    step();
    idle();
    check("excp_hold_pc0", out_entry[0].vaddr, 32'h1c00_2000);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check("excp_dropped", out_valid, 2'b00);
    check("excp_still_held", in_ready, 1'b0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("excp_flush_ready", in_ready, 1'b1);
    check("excp_flush_valid", out_valid, 2'b00);

    // flush and reset mid-operation
    midop(1'b0, 32'h1c00_3000);
    midop(1'b1, 32'h1c00_4000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
